wager_ledger: RTL and testbench

WAGER_LEDGER -- requirements
Module: wager_ledger

---
 rtl/wager_ledger_if.sv | 25 ++
 rtl/wager_ledger.sv | 144 ++++++++++++++
 tb/tb_wager_ledger.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/wager_ledger_if.sv
// Wager ledger bus: the bet request inputs and the ledger status outputs.
// load_wager is a one-cycle request with an implicit ready that is high only in IDLE or DONE; a request in any other state is dropped, not queued.
interface wager_ledger_if;
    logic       load_wager;
    logic [1:0] bet_in;
    logic [3:0] bet_amount;
    logic [1:0] result;
    logic [7:0] balance;
    logic [3:0] stake;
    logic [1:0] bet_held;
    logic       settled;
    logic [1:0] outcome;
    logic       broke;
    logic [2:0] fsm_state;

    modport master (
        output load_wager, bet_in, bet_amount, result,
        input  balance, stake, bet_held, settled, outcome, broke, fsm_state
    );

    modport slave (
        input  load_wager, bet_in, bet_amount, result,
        output balance, stake, bet_held, settled, outcome, broke, fsm_state
    );
endinterface

// File: rtl/wager_ledger.sv
// Credit ledger for a single-bet game: takes a stake, waits for a result,
// pays out with saturation at 255 and reports the outcome of the round.
module wager_ledger #(
    parameter logic [7:0] INIT_BALANCE = 8'd100,
    parameter int         TIE_ODDS     = 8
) (
    input  logic             slow_clock,
    input  logic             reset,
    wager_ledger_if.slave    bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        STAKED = 3'd1,
        SETTLE = 3'd2,
        DONE   = 3'd3
    } state_t;

    localparam logic [1:0] BET_NONE   = 2'b00;
    localparam logic [1:0] BET_TIE    = 2'b11;
    localparam logic [1:0] RES_TIE    = 2'b11;
    localparam logic [1:0] OUT_NONE   = 2'b00;
    localparam logic [1:0] OUT_WIN    = 2'b01;
    localparam logic [1:0] OUT_LOSS   = 2'b10;
    localparam logic [1:0] OUT_PUSH   = 2'b11;
    localparam int         TIE_MULT   = TIE_ODDS + 1;

    state_t     state, state_nxt;
    logic [7:0] balance, balance_nxt;
    logic [3:0] stake, stake_nxt;
    logic [1:0] bet_held, bet_held_nxt;
    logic [1:0] outcome, outcome_nxt;
    logic [1:0] result_q, result_q_nxt;
    logic       settled, settled_nxt;

    logic [3:0]  eff_stake;
    logic [15:0] payout;
    logic [1:0]  pay_outcome;
    logic [16:0] pay_sum;
    logic [7:0]  pay_balance;
    logic        accept;

    // Stake is clamped to what the player can cover; a no-bet round stakes nothing.
    always_comb begin
        eff_stake = bus.bet_amount;
        if (bus.bet_in == BET_NONE) begin
            eff_stake = 4'd0;
        end else if ({4'd0, bus.bet_amount} > balance) begin
            eff_stake = balance[3:0];
        end
    end

    always_comb begin
        payout      = 16'd0;
        pay_outcome = OUT_LOSS;
        if (bet_held == BET_NONE) begin
            pay_outcome = OUT_PUSH;
        end else if (bet_held == result_q) begin
            pay_outcome = OUT_WIN;
            if (bet_held == BET_TIE) begin
                payout = 16'(stake) * 16'(TIE_MULT);
            end else begin
                payout = {11'd0, stake, 1'b0};
            end
        end else if (result_q == RES_TIE) begin
            pay_outcome = OUT_PUSH;
            payout      = {12'd0, stake};
        end
    end

    // Sum is kept wide so a large tie payout clips to 255 instead of wrapping.
    always_comb begin
        pay_sum     = {9'd0, balance} + {1'b0, payout};
        pay_balance = (pay_sum > 17'd255) ? 8'hFF : pay_sum[7:0];
    end

    assign accept = bus.load_wager && ((state == IDLE) || (state == DONE));

    always_comb begin
        state_nxt    = state;
        balance_nxt  = balance;
        stake_nxt    = stake;
        bet_held_nxt = bet_held;
        outcome_nxt  = outcome;
        result_q_nxt = result_q;
        settled_nxt  = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (accept) begin
                    state_nxt    = STAKED;
                    bet_held_nxt = bus.bet_in;
                    stake_nxt    = eff_stake;
                    balance_nxt  = balance - {4'd0, eff_stake};
                    outcome_nxt  = OUT_NONE;
                end
            end
            STAKED: begin
                if (bus.result != 2'b00) begin
                    result_q_nxt = bus.result;
                    state_nxt    = SETTLE;
                end
            end
            SETTLE: begin
                balance_nxt = pay_balance;
                outcome_nxt = pay_outcome;
                stake_nxt   = 4'd0;
                settled_nxt = 1'b1;
                state_nxt   = DONE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge slow_clock) begin
        if (reset) begin
            state    <= IDLE;
            balance  <= INIT_BALANCE;
            stake    <= 4'd0;
            bet_held <= BET_NONE;
            outcome  <= OUT_NONE;
            result_q <= 2'b00;
            settled  <= 1'b0;
        end else begin
            state    <= state_nxt;
            balance  <= balance_nxt;
            stake    <= stake_nxt;
            bet_held <= bet_held_nxt;
            outcome  <= outcome_nxt;
            result_q <= result_q_nxt;
            settled  <= settled_nxt;
        end
    end

    assign bus.balance   = balance;
    assign bus.stake     = stake;
    assign bus.bet_held  = bet_held;
    assign bus.outcome   = outcome;
    assign bus.settled   = settled;
    assign bus.broke     = (balance == 8'd0) && ((state == IDLE) || (state == DONE));
    assign bus.fsm_state = state;

endmodule

// File: tb/tb_wager_ledger.sv
// Bench for wager_ledger: directed rounds from the requirement examples,
// then randomized rounds checked against a round-level credit model.
module tb_wager_ledger;

    localparam int TIE_ODDS = 8;
    localparam int INIT_BAL = 100;

    logic slow_clock;
    logic reset;
    wager_ledger_if bus ();

    wager_ledger #(
        .INIT_BALANCE(8'(INIT_BAL)),
        .TIE_ODDS    (TIE_ODDS)
    ) dut (
        .slow_clock(slow_clock),
        .reset     (reset),
        .bus       (bus)
    );

    initial slow_clock = 1'b0;
    always #5 slow_clock = ~slow_clock;

    int n_vec  = 0;
    int n_miss = 0;

    // Round-level model state
    int m_bal;
    int m_stake;
    int m_bet;
    int m_out;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge slow_clock);
        #1;
    endtask

    task automatic model_reset();
        m_bal   = INIT_BAL;
        m_stake = 0;
        m_bet   = 0;
        m_out   = 0;
    endtask

    task automatic check_idle_after_reset(input string tag);
        check_eq({tag, "_balance"}, int'(bus.balance), m_bal);
        check_eq({tag, "_stake"}, int'(bus.stake), 0);
        check_eq({tag, "_bet_held"}, int'(bus.bet_held), 0);
        check_eq({tag, "_outcome"}, int'(bus.outcome), 0);
        check_eq({tag, "_settled"}, int'(bus.settled), 0);
        check_eq({tag, "_state_idle"}, int'(bus.fsm_state), 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.load_wager = 1'b1;
        bus.bet_in     = 2'($urandom_range(0, 3));
        bus.bet_amount = 4'($urandom_range(0, 15));
        bus.result     = 2'($urandom_range(1, 3));
        tick();
        reset = 1'b0;
        bus.load_wager = 1'b0;
        bus.result     = 2'b00;
        model_reset();
        check_idle_after_reset("reset");
    endtask

    task automatic place(input int b, input int a);
        int eff;
        eff = (b == 0) ? 0 : ((a < m_bal) ? a : m_bal);
        bus.load_wager = 1'b1;
        bus.bet_in     = 2'(b);
        bus.bet_amount = 4'(a);
        bus.result     = 2'($urandom_range(0, 3));
        tick();
        bus.load_wager = 1'b0;
        bus.result     = 2'b00;
        m_bal   = m_bal - eff;
        m_stake = eff;
        m_bet   = b;
        m_out   = 0;
        check_eq("place_balance", int'(bus.balance), m_bal);
        check_eq("place_stake", int'(bus.stake), m_stake);
        check_eq("place_bet_held", int'(bus.bet_held), m_bet);
        check_eq("place_outcome", int'(bus.outcome), 0);
        check_eq("place_broke", int'(bus.broke), 0);
    endtask

    task automatic resolve(input int res, input int holds, input bit noise);
        int pay;
        int oc;
        for (int i = 0; i < holds; i++) begin
            bus.result = 2'b00;
            if (noise) begin
                bus.load_wager = 1'b1;
                bus.bet_in     = 2'($urandom_range(0, 3));
                bus.bet_amount = 4'($urandom_range(0, 15));
            end
            tick();
            bus.load_wager = 1'b0;
            check_eq("hold_balance", int'(bus.balance), m_bal);
            check_eq("hold_stake", int'(bus.stake), m_stake);
            check_eq("hold_bet_held", int'(bus.bet_held), m_bet);
            check_eq("hold_settled", int'(bus.settled), 0);
        end
        bus.result = 2'(res);
        tick();
        bus.result = 2'($urandom_range(0, 3));
        check_eq("settle_balance_pre", int'(bus.balance), m_bal);
        check_eq("settle_settled_pre", int'(bus.settled), 0);
        tick();
        if (m_bet == 0) begin
            pay = 0; oc = 3;
        end else if (m_bet == res) begin
            pay = (m_bet == 3) ? (TIE_ODDS + 1) * m_stake : 2 * m_stake;
            oc  = 1;
        end else if (res == 3) begin
            pay = m_stake; oc = 3;
        end else begin
            pay = 0; oc = 2;
        end
        m_bal   = (m_bal + pay > 255) ? 255 : m_bal + pay;
        m_stake = 0;
        m_out   = oc;
        check_eq("done_balance", int'(bus.balance), m_bal);
        check_eq("done_stake", int'(bus.stake), 0);
        check_eq("done_outcome", int'(bus.outcome), m_out);
        check_eq("done_settled", int'(bus.settled), 1);
        check_eq("done_bet_held", int'(bus.bet_held), m_bet);
        check_eq("done_broke", int'(bus.broke), (m_bal == 0) ? 1 : 0);
        bus.result = 2'($urandom_range(0, 3));
        tick();
        bus.result = 2'b00;
        check_eq("after_settled", int'(bus.settled), 0);
        check_eq("after_balance", int'(bus.balance), m_bal);
        check_eq("after_outcome", int'(bus.outcome), m_out);
    endtask

    task automatic reset_in_staked();
        reset = 1'b1;
        bus.result = 2'($urandom_range(1, 3));
        tick();
        reset = 1'b0;
        bus.result = 2'b00;
        model_reset();
        check_idle_after_reset("stk_reset");
        for (int i = 0; i < 3; i++) begin
            bus.result = 2'($urandom_range(1, 3));
            tick();
            check_eq("stk_reset_no_settle", int'(bus.settled), 0);
            check_eq("stk_reset_balance", int'(bus.balance), INIT_BAL);
        end
        bus.result = 2'b00;
    endtask

    initial begin
        reset          = 1'b1;
        bus.load_wager = 1'b0;
        bus.bet_in     = 2'b00;
        bus.bet_amount = 4'd0;
        bus.result     = 2'b00;
        tick();
        tick();
        do_reset();

        // Player win
        place(1, 10);
        check_eq("win_bal_after_stake", int'(bus.balance), 90);
        check_eq("win_stake", int'(bus.stake), 10);
        resolve(1, 1, 1'b0);
        check_eq("win_bal_final", int'(bus.balance), 110);
        check_eq("win_outcome", int'(bus.outcome), 1);

        // Tie bet win
        do_reset();
        place(3, 5);
        check_eq("tie_bal_after_stake", int'(bus.balance), 95);
        resolve(3, 0, 1'b0);
        check_eq("tie_bal_final", int'(bus.balance), 140);
        check_eq("tie_outcome", int'(bus.outcome), 1);

        // Push then loss
        do_reset();
        place(1, 8);
        resolve(3, 2, 1'b0);
        check_eq("push_bal", int'(bus.balance), 100);
        check_eq("push_outcome", int'(bus.outcome), 3);
        place(2, 8);
        resolve(1, 0, 1'b0);
        check_eq("loss_bal", int'(bus.balance), 92);
        check_eq("loss_outcome", int'(bus.outcome), 2);

        // No-bet round
        place(0, 9);
        check_eq("nobet_stake", int'(bus.stake), 0);
        resolve(2, 0, 1'b0);
        check_eq("nobet_outcome", int'(bus.outcome), 3);

        // Drain to 3, clamp, go broke, then play at zero
        do_reset();
        for (int i = 0; i < 6; i++) begin
            place(2, 15);
            resolve(1, 0, 1'b0);
        end
        place(2, 7);
        resolve(1, 0, 1'b0);
        check_eq("drain_bal", int'(bus.balance), 3);
        place(1, 15);
        check_eq("clamp_stake", int'(bus.stake), 3);
        resolve(2, 0, 1'b0);
        check_eq("broke_bal", int'(bus.balance), 0);
        check_eq("broke_flag", int'(bus.broke), 1);
        place(1, 9);
        check_eq("zero_stake", int'(bus.stake), 0);
        resolve(1, 0, 1'b0);
        check_eq("zero_win_bal", int'(bus.balance), 0);
        check_eq("zero_broke", int'(bus.broke), 1);

        // Climb to 250, then saturate with a tie win
        do_reset();
        place(3, 15); resolve(3, 0, 1'b0);
        place(1, 15); resolve(1, 0, 1'b0);
        place(1, 15); resolve(1, 0, 1'b0);
        check_eq("climb_bal", int'(bus.balance), 250);
        place(3, 15); resolve(3, 0, 1'b0);
        check_eq("sat_bal", int'(bus.balance), 255);

        // Loads during STAKED are ignored; reset in STAKED forfeits the stake
        do_reset();
        place(1, 10);
        resolve(2, 3, 1'b1);
        check_eq("ignore_bal", int'(bus.balance), 90);
        place(2, 6);
        tick();
        reset_in_staked();

        // Randomized rounds
        for (int r = 0; r < 250; r++) begin
            if ($urandom_range(0, 19) == 0) begin
                place(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
                reset_in_staked();
            end else begin
                place(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
                resolve(int'($urandom_range(1, 3)), int'($urandom_range(0, 3)),
                        1'($urandom_range(0, 1)));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
